// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter_if
// Brief    : Requester (inst/data) and downstream memory bundle for the arbiter.
// Revision : 1.0
// ============================================================================
interface sram_port_arbiter_if;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    logic        protocol_err;

    // Arbiter side
    modport slave (
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output protocol_err
    );

    // Environment side: requesters and memory bridge
    modport master (
        output inst_req, inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  protocol_err
    );
endinterface
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Brief    : Shares one sram-like port between inst and data requesters,
//            routing in-order responses back through an owner tag FIFO.
// Revision : 1.0
// ============================================================================
module sram_port_arbiter #(
    parameter int OUTSTANDING = 4,
    parameter int STARVE_MAX  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_port_arbiter_if.slave   bus
);
    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = PW + 1;
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] c_full       = CW'(OUTSTANDING);
    localparam logic [SW-1:0] c_starve_max = SW'(STARVE_MAX);

    // Tag 0 = inst, 1 = data
    logic [OUTSTANDING-1:0] r_tags;
    logic [PW-1:0]          r_rd_ptr;
    logic [PW-1:0]          r_wr_ptr;
    logic [CW-1:0]          r_count;
    logic                   r_lock;
    logic                   r_locked_owner;
    logic [SW-1:0]          r_starve_cnt;
    logic                   r_protocol_err;

    logic w_owner;
    logic w_granted_req;
    logic w_full;
    logic w_fire;
    logic w_pop;
    logic w_head;

    always_comb begin
        w_owner = 1'b1;
        if (r_lock)
            w_owner = r_locked_owner;
        else if (bus.inst_req && !bus.data_req)
            w_owner = 1'b0;
        else if (bus.inst_req && bus.data_req && (r_starve_cnt == c_starve_max))
            w_owner = 1'b0;
    end

    assign w_granted_req = w_owner ? bus.data_req : bus.inst_req;
    // Fullness uses the registered count, so a same-cycle pop never frees a slot
    assign w_full        = (r_count == c_full);
    assign w_fire        = bus.mem_req & bus.mem_addr_ok;
    assign w_pop         = bus.mem_data_ok & (r_count != '0);
    assign w_head        = r_tags[r_rd_ptr];

    assign bus.mem_req      = w_granted_req & ~w_full;
    assign bus.mem_wr       = w_owner ? bus.data_wr    : bus.inst_wr;
    assign bus.mem_size     = w_owner ? bus.data_size  : bus.inst_size;
    assign bus.mem_addr     = w_owner ? bus.data_addr  : bus.inst_addr;
    assign bus.mem_wstrb    = w_owner ? bus.data_wstrb : bus.inst_wstrb;
    assign bus.mem_wdata    = w_owner ? bus.data_wdata : bus.inst_wdata;

    assign bus.inst_addr_ok = w_fire & ~w_owner;
    assign bus.data_addr_ok = w_fire &  w_owner;
    assign bus.inst_data_ok = w_pop  & ~w_head;
    assign bus.data_data_ok = w_pop  &  w_head;
    assign bus.inst_rdata   = bus.mem_rdata;
    assign bus.data_rdata   = bus.mem_rdata;
    assign bus.protocol_err = r_protocol_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tags         <= '0;
            r_rd_ptr       <= '0;
            r_wr_ptr       <= '0;
            r_count        <= '0;
            r_lock         <= 1'b0;
            r_locked_owner <= 1'b0;
            r_starve_cnt   <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            if (w_fire) begin
                r_tags[r_wr_ptr] <= w_owner;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_fire) - CW'(w_pop);

            if (bus.mem_data_ok && (r_count == '0))
                r_protocol_err <= 1'b1;

            // Hold the owner of a stalled request so the downstream never sees it swap
            if (w_fire) begin
                r_lock <= 1'b0;
            end else if (bus.mem_req) begin
                r_lock         <= 1'b1;
                r_locked_owner <= w_owner;
            end

            if (!bus.inst_req) begin
                r_starve_cnt <= '0;
            end else if (w_fire) begin
                if (!w_owner)
                    r_starve_cnt <= '0;
                else if (r_starve_cnt != c_starve_max)
                    r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Brief    : Directed stimulus with a queue-based grant/response scoreboard.
// Revision : 1.0
// ============================================================================
module tb_sram_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_port_arbiter_if bus ();

    sram_port_arbiter #(
        .OUTSTANDING (4),
        .STARVE_MAX  (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { logic owner; logic [31:0] addr;  } grant_t;
    typedef struct { logic owner; logic [31:0] rdata; } rsp_t;

    grant_t exp_grant[$];
    rsp_t   exp_rsp[$];
    grant_t mg;
    rsp_t   mr;
    int     total = 0;
    int     bad   = 0;

    localparam logic [38:0] c_inst_fields = {1'b0, 2'd2, 4'h0, 32'h11110000};
    localparam logic [38:0] c_data_fields = {1'b1, 2'd1, 4'h3, 32'hDDDD0000};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_g(input logic owner, input logic [31:0] addr);
        grant_t g;
        g.owner = owner;
        g.addr  = addr;
        exp_grant.push_back(g);
    endtask

    task automatic exp_r(input logic owner, input logic [31:0] rdata);
        rsp_t r;
        r.owner = owner;
        r.rdata = rdata;
        exp_rsp.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals accept or response
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.inst_addr_ok || bus.data_addr_ok) begin
                if (exp_grant.size() == 0) begin
                    chk("unexpected_grant", {62'd0, bus.inst_addr_ok, bus.data_addr_ok}, 64'd0);
                end else begin
                    mg = exp_grant.pop_front();
                    chk("grant_owner", {62'd0, bus.inst_addr_ok, bus.data_addr_ok},
                        mg.owner ? 64'd1 : 64'd2);
                    chk("grant_addr", {32'd0, bus.mem_addr}, {32'd0, mg.addr});
                    chk("grant_fields",
                        {25'd0, bus.mem_wr, bus.mem_size, bus.mem_wstrb, bus.mem_wdata},
                        {25'd0, mg.owner ? c_data_fields : c_inst_fields});
                end
            end
            if (bus.inst_data_ok || bus.data_data_ok) begin
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", {62'd0, bus.inst_data_ok, bus.data_data_ok}, 64'd0);
                end else begin
                    mr = exp_rsp.pop_front();
                    chk("rsp_owner", {62'd0, bus.inst_data_ok, bus.data_data_ok},
                        mr.owner ? 64'd1 : 64'd2);
                    chk("rsp_inst_rdata", {32'd0, bus.inst_rdata}, {32'd0, mr.rdata});
                    chk("rsp_data_rdata", {32'd0, bus.data_rdata}, {32'd0, mr.rdata});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic        g2 [8];
    logic        o5 [3];
    logic [31:0] d5 [3];

    initial begin
        g2 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        o5 = '{1'b0, 1'b1, 1'b0};
        d5 = '{32'h11, 32'h22, 32'h33};

        reset           = 1'b1;
        bus.inst_req    = 1'b0;
        bus.inst_wr     = 1'b0;
        bus.inst_size   = 2'd2;
        bus.inst_addr   = '0;
        bus.inst_wstrb  = 4'h0;
        bus.inst_wdata  = 32'h11110000;
        bus.data_req    = 1'b0;
        bus.data_wr     = 1'b1;
        bus.data_size   = 2'd1;
        bus.data_addr   = '0;
        bus.data_wstrb  = 4'h3;
        bus.data_wdata  = 32'hDDDD0000;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = '0;

        // Reset state
        @(negedge clk);
        chk("reset_mem_req", {63'd0, bus.mem_req}, 64'd0);
        chk("reset_oks", {60'd0, bus.inst_addr_ok, bus.data_addr_ok,
                          bus.inst_data_ok, bus.data_data_ok}, 64'd0);
        chk("reset_perr", {63'd0, bus.protocol_err}, 64'd0);
        tick();
        reset = 1'b0;

        // 1: single inst request, response one cycle later
        bus.inst_req    = 1'b1;
        bus.inst_addr   = 32'h1C000000;
        bus.mem_addr_ok = 1'b1;
        exp_g(1'b0, 32'h1C000000);
        @(negedge clk);
        chk("t1_mem_req", {63'd0, bus.mem_req}, 64'd1);
        tick();
        bus.inst_req    = 1'b0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h1C000000;
        exp_r(1'b0, 32'h1C000000);
        tick();
        bus.mem_data_ok = 1'b0;
        tick();

        // 2: both requesting, starvation guard gives D,D,D,I,...
        bus.inst_addr = 32'h1C000100;
        bus.data_addr = 32'h80000100;
        for (int k = 0; k < 9; k++) begin
            bus.inst_req    = (k < 8);
            bus.data_req    = (k < 8);
            bus.mem_addr_ok = (k < 8);
            if (k < 8) exp_g(g2[k], g2[k] ? 32'h80000100 : 32'h1C000100);
            bus.mem_data_ok = (k >= 1);
            bus.mem_rdata   = 32'h100 + k;
            if (k >= 1) exp_r(g2[k-1], 32'h100 + k);
            tick();
        end
        bus.mem_data_ok = 1'b0;

        // 3: stalled inst request keeps ownership when data arrives
        bus.inst_req    = 1'b1;
        bus.inst_addr   = 32'h1C000040;
        bus.data_addr   = 32'h80000040;
        bus.mem_addr_ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.data_req = (k == 2);
            @(negedge clk);
            chk("t3_lock_addr", {32'd0, bus.mem_addr}, {32'd0, 32'h1C000040});
            chk("t3_req_held", {63'd0, bus.mem_req}, 64'd1);
            tick();
        end
        bus.mem_addr_ok = 1'b1;
        exp_g(1'b0, 32'h1C000040);
        tick();
        bus.inst_req = 1'b0;
        exp_g(1'b1, 32'h80000040);
        tick();
        bus.data_req    = 1'b0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h31;
        exp_r(1'b0, 32'h31);
        tick();
        bus.mem_rdata = 32'h32;
        exp_r(1'b1, 32'h32);
        tick();
        bus.mem_data_ok = 1'b0;

        // 4: fill the tag FIFO, then pop while full
        bus.data_req    = 1'b1;
        bus.mem_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.data_addr = 32'h80000000 + 4 * k;
            exp_g(1'b1, 32'h80000000 + 4 * k);
            tick();
        end
        bus.data_addr = 32'h80000010;
        @(negedge clk);
        chk("t4_full_req", {63'd0, bus.mem_req}, 64'd0);
        tick();
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h40;
        exp_r(1'b1, 32'h40);
        @(negedge clk);
        chk("t4_full_pop_req", {63'd0, bus.mem_req}, 64'd0);
        tick();
        bus.mem_data_ok = 1'b0;
        exp_g(1'b1, 32'h80000010);
        @(negedge clk);
        chk("t4_after_pop_req", {63'd0, bus.mem_req}, 64'd1);
        tick();
        bus.data_req    = 1'b0;
        bus.mem_addr_ok = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.mem_data_ok = 1'b1;
            bus.mem_rdata   = 32'h41 + k;
            exp_r(1'b1, 32'h41 + k);
            tick();
        end
        bus.mem_data_ok = 1'b0;

        // 5: interleaved tags route responses to the right requester
        bus.mem_addr_ok = 1'b1;
        bus.inst_req    = 1'b1;
        bus.inst_addr   = 32'h1C000200;
        exp_g(1'b0, 32'h1C000200);
        tick();
        bus.inst_req  = 1'b0;
        bus.data_req  = 1'b1;
        bus.data_addr = 32'h80000200;
        exp_g(1'b1, 32'h80000200);
        tick();
        bus.data_req  = 1'b0;
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h1C000204;
        exp_g(1'b0, 32'h1C000204);
        tick();
        bus.inst_req    = 1'b0;
        bus.mem_addr_ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.mem_data_ok = 1'b1;
            bus.mem_rdata   = d5[k];
            exp_r(o5[k], d5[k]);
            tick();
        end
        bus.mem_data_ok = 1'b0;

        // 6: response with nothing outstanding, then async reset mid-flight
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'hBAD;
        @(negedge clk);
        chk("t6_no_data_ok", {62'd0, bus.inst_data_ok, bus.data_data_ok}, 64'd0);
        tick();
        bus.mem_data_ok = 1'b0;
        @(negedge clk);
        chk("t6_perr_set", {63'd0, bus.protocol_err}, 64'd1);
        tick();
        bus.inst_req    = 1'b1;
        bus.mem_addr_ok = 1'b1;
        bus.inst_addr   = 32'h1C000300;
        exp_g(1'b0, 32'h1C000300);
        tick();
        bus.inst_addr = 32'h1C000304;
        exp_g(1'b0, 32'h1C000304);
        tick();
        bus.inst_req    = 1'b0;
        bus.mem_addr_ok = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_perr_clr", {63'd0, bus.protocol_err}, 64'd0);
        tick();
        reset = 1'b0;
        bus.mem_data_ok = 1'b1;
        @(negedge clk);
        chk("t6_post_reset_no_ok", {62'd0, bus.inst_data_ok, bus.data_data_ok}, 64'd0);
        tick();
        bus.mem_data_ok = 1'b0;
        @(negedge clk);
        chk("t6_post_reset_perr", {63'd0, bus.protocol_err}, 64'd1);
        tick();

        chk("grant_queue_drained", 64'(exp_grant.size()), 64'd0);
        chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
